// File: rtl/aes_req_sched.sv
// Two-requester round-robin front end for a fixed-latency, non-stallable AES-128 core.
// Optional saturating statistics counters are enabled with `define AES_SCHED_STATS_EN.

module aes_req_sched_fifo #(
  parameter int W     = 128,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_valid,
  output logic         o_full,
  output logic [W-1:0] o_data
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  r_wp;
  logic [AW:0]  r_rp;
  logic [W-1:0] r_mem [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp <= '0;
      r_rp <= '0;
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wp[AW-1:0]] <= i_data;
        r_wp                <= r_wp + 1'b1;
      end
      if (i_pop && o_valid) r_rp <= r_rp + 1'b1;
    end
  end

  assign o_valid = (r_wp != r_rp);
  assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign o_data  = r_mem[r_rp[AW-1:0]];
endmodule

module aes_req_sched #(
  parameter int PIPE_LAT  = 21,
  parameter int RSP_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_req0_valid,
  output logic         o_req0_ready,
  input  logic [127:0] i_req0_state,
  input  logic [127:0] i_req0_key,
  input  logic         i_req1_valid,
  output logic         o_req1_ready,
  input  logic [127:0] i_req1_state,
  input  logic [127:0] i_req1_key,
  output logic         o_rsp0_valid,
  input  logic         i_rsp0_ready,
  output logic [127:0] o_rsp0_data,
  output logic         o_rsp1_valid,
  input  logic         i_rsp1_ready,
  output logic [127:0] o_rsp1_data,
  output logic [127:0] o_core_state,
  output logic [127:0] o_core_key,
  input  logic [127:0] i_core_out
`ifdef AES_SCHED_STATS_EN
  ,
  output logic [31:0]  o_stat_issue0,
  output logic [31:0]  o_stat_issue1,
  output logic [31:0]  o_stat_stall
`endif
);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam logic [CW-1:0] C_MAX = CW'(RSP_DEPTH);

  logic [127:0]      r_core_state;
  logic [127:0]      r_core_key;
  logic              r_last_grant;
  logic [PIPE_LAT:0] r_sv;
  logic [PIPE_LAT:0] r_st;
  logic [CW-1:0]     r_out0;
  logic [CW-1:0]     r_out1;

  logic w_elig0, w_elig1, w_gnt0, w_gnt1, w_issue;
  logic w_push0, w_push1, w_pop0, w_pop1;
  logic w_full0, w_full1;

  function automatic logic [CW-1:0] f_credit(input logic [CW-1:0] c, input logic inc,
                                             input logic dec);
    case ({inc, dec})
      2'b10:   return c + 1'b1;
      2'b01:   return c - 1'b1;
      default: return c;
    endcase
  endfunction

  assign w_elig0 = i_req0_valid && (r_out0 < C_MAX);
  assign w_elig1 = i_req1_valid && (r_out1 < C_MAX);

  // On contention the requester that did not win last time is granted.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (w_elig0 && w_elig1) begin
      if (r_last_grant) w_gnt0 = 1'b1;
      else              w_gnt1 = 1'b1;
    end else begin
      w_gnt0 = w_elig0;
      w_gnt1 = w_elig1;
    end
  end

  assign w_issue      = w_gnt0 || w_gnt1;
  assign o_req0_ready = w_gnt0;
  assign o_req1_ready = w_gnt1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_core_state <= '0;
      r_core_key   <= '0;
      r_last_grant <= 1'b1;
      r_sv         <= '0;
      r_st         <= '0;
      r_out0       <= '0;
      r_out1       <= '0;
    end else begin
      if (w_issue) begin
        r_core_state <= w_gnt1 ? i_req1_state : i_req0_state;
        r_core_key   <= w_gnt1 ? i_req1_key   : i_req0_key;
        r_last_grant <= w_gnt1;
      end
      r_sv   <= {r_sv[PIPE_LAT-1:0], w_issue};
      r_st   <= {r_st[PIPE_LAT-1:0], w_gnt1};
      r_out0 <= f_credit(r_out0, w_gnt0, w_pop0);
      r_out1 <= f_credit(r_out1, w_gnt1, w_pop1);
    end
  end

  assign o_core_state = r_core_state;
  assign o_core_key   = r_core_key;

  // Last tracking stage lines up with the core result currently on i_core_out.
  assign w_push0 = r_sv[PIPE_LAT] && !r_st[PIPE_LAT];
  assign w_push1 = r_sv[PIPE_LAT] &&  r_st[PIPE_LAT];
  assign w_pop0  = o_rsp0_valid && i_rsp0_ready;
  assign w_pop1  = o_rsp1_valid && i_rsp1_ready;

  aes_req_sched_fifo #(.W(128), .DEPTH(RSP_DEPTH)) u_fifo0 (
    .clk(clk), .reset(reset), .i_push(w_push0), .i_data(i_core_out), .i_pop(i_rsp0_ready),
    .o_valid(o_rsp0_valid), .o_full(w_full0), .o_data(o_rsp0_data)
  );

  aes_req_sched_fifo #(.W(128), .DEPTH(RSP_DEPTH)) u_fifo1 (
    .clk(clk), .reset(reset), .i_push(w_push1), .i_data(i_core_out), .i_pop(i_rsp1_ready),
    .o_valid(o_rsp1_valid), .o_full(w_full1), .o_data(o_rsp1_data)
  );

`ifdef AES_SCHED_STATS_EN
  logic [31:0] r_stat_issue0;
  logic [31:0] r_stat_issue1;
  logic [31:0] r_stat_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat_issue0 <= '0;
      r_stat_issue1 <= '0;
      r_stat_stall  <= '0;
    end else begin
      if (w_gnt0 && (r_stat_issue0 != 32'hFFFF_FFFF)) r_stat_issue0 <= r_stat_issue0 + 1'b1;
      if (w_gnt1 && (r_stat_issue1 != 32'hFFFF_FFFF)) r_stat_issue1 <= r_stat_issue1 + 1'b1;
      if ((i_req0_valid || i_req1_valid) && !w_issue && (r_stat_stall != 32'hFFFF_FFFF))
        r_stat_stall <= r_stat_stall + 1'b1;
    end
  end

  assign o_stat_issue0 = r_stat_issue0;
  assign o_stat_issue1 = r_stat_issue1;
  assign o_stat_stall  = r_stat_stall;
`endif
endmodule
